// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: buffers stereo samples captured on audio_stb and hands them to the
// HDMI audio packetizer through a registered first-word-fall-through valid/ready port.
`default_nettype none

module audio_sample_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  audio_stb,
  input  logic [WIDTH-1:0]      audio_l,
  input  logic [WIDTH-1:0]      audio_r,
  input  logic                  mute,
  input  logic                  clear,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_l,
  output logic [WIDTH-1:0]      out_r,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underrun
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [2*WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] head_idx;
  logic [2*WIDTH-1:0]    wr_data;
  logic                  primed;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push;
  logic                  head_avail;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign pop     = out_valid & out_ready;
  assign push    = audio_stb & (~full | pop);
  assign wr_data = mute ? '0 : {audio_l, audio_r};

  // Next head to present: a sample written on this same edge is not visible until the next
  // one, which gives the one-cycle fall-through latency from an empty FIFO.
  always_comb begin
    head_idx   = rd_ptr;
    head_avail = ~empty;
    if (pop) begin
      head_idx   = rd_ptr + PTR_ONE;
      head_avail = (level > LEVEL_ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
      primed    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        primed <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (audio_stb && !push) begin
        overflow <= 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
      // Output register only reloads when it is empty or its content is being consumed.
      if (!out_valid || pop) begin
        out_valid <= head_avail;
        if (head_avail) begin
          {out_l, out_r} <= mem[head_idx];
        end
      end
      underrun <= primed & empty & out_ready;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo: directed scenarios plus random traffic against a
// queue-based reference model.
`default_nettype none

module tb_audio_sample_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        audio_stb;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
  logic        mute;
  logic        clear;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_l;
  logic [15:0] out_r;
  logic [4:0]  level;
  logic        overflow;
  logic        underrun;

  audio_sample_fifo #(.WIDTH(16), .DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .audio_stb (audio_stb),
    .audio_l   (audio_l),
    .audio_r   (audio_r),
    .mute      (mute),
    .clear     (clear),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_l     (out_l),
    .out_r     (out_r),
    .level     (level),
    .overflow  (overflow),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          pops     = 0;
  int          und_cnt  = 0;
  logic [31:0] last_pop = '0;

  // Reference model: stored samples in arrival order plus sticky/pulse flags.
  logic [31:0] q[$];
  bit          m_ovf    = 0;
  bit          m_primed = 0;
  bit          m_und    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf    = 0;
    m_primed = 0;
    m_und    = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; audio_stb = 1'b0; audio_l = '0; audio_r = '0;
    mute = 1'b0; clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // One clock cycle: drive inputs, score any handshake, advance the model, check after the edge.
  task automatic step(input logic stb, input logic [15:0] l, input logic [15:0] r,
                      input logic mu, input logic rdy, input logic clr);
    logic pop;
    bit   was_full;
    bit   und_n;
    audio_stb = stb; audio_l = l; audio_r = r; mute = mu; out_ready = rdy; clear = clr;
    pop = out_valid && rdy && !clr;
    if (out_valid) chk("valid_nonempty", 64'(q.size() != 0), 64'd1);
    if (pop && q.size() != 0) begin
      chk("pop_data", 64'({out_l, out_r}), 64'(q[0]));
      last_pop = {out_l, out_r};
      pops++;
    end
    if (clr) begin
      model_clear();
      und_n = 0;
    end else begin
      und_n    = m_primed && (q.size() == 0) && rdy;
      was_full = (q.size() == 16);
      if (pop && q.size() != 0) void'(q.pop_front());
      if (stb && (!was_full || pop)) begin
        q.push_back(mu ? 32'h0 : {l, r});
        m_primed = 1;
      end else if (stb) begin
        m_ovf = 1;
      end
    end
    m_und = und_n;
    @(posedge clk);
    #1;
    chk("level", 64'(level), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("underrun", 64'(underrun), 64'(m_und));
    if (underrun) und_cnt++;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 16'h0, 16'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 60) begin
      idle(1'b1);
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  logic [31:0] got[3];

  initial begin
    do_reset();
    @(posedge clk); #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'({out_l, out_r}), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_und", 64'(underrun), 64'd0);

    // Ready with nothing ever pushed must not report underrun.
    repeat (3) begin
      idle(1'b1);
      chk("und_unprimed", 64'(underrun), 64'd0);
    end

    // Single sample: visible one cycle after capture, held while not ready.
    step(1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0);
    chk("fwft_latency", 64'(out_valid), 64'd0);
    idle(1'b0);
    chk("fwft_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_l", 64'(out_l), 64'h1234);
      chk("hold_r", 64'(out_r), 64'hABCD);
    end
    drain();

    // Overfill: 17 strobes, 16 kept, 17th dropped.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 16'(i + 1), 16'(16'hF000 + i), 1'b0, 1'b0, 1'b0);
    chk("full_level", 64'(level), 64'd16);
    chk("full_ovf", 64'(overflow), 64'd1);
    pops = 0;
    drain();
    chk("drain_count", 64'(pops), 64'd16);
    chk("drain_last", 64'(last_pop), 64'h0010F00F);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_level", 64'(level), 64'd0);

    // Underrun: primed and empty with ready for three cycles.
    idle(1'b0);
    und_cnt = 0;
    repeat (3) idle(1'b1);
    idle(1'b0);
    chk("und_pulses", 64'(und_cnt), 64'd3);

    // Full FIFO, simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h0100 + i), 16'(i), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b1, 16'hBEEF, 16'hCAFE, 1'b0, 1'b1, 1'b0);
    chk("fullpp_level", 64'(level), 64'd16);
    chk("fullpp_ovf", 64'(overflow), 64'd0);
    pops = 0;
    drain();
    chk("fullpp_count", 64'(pops), 64'd16);
    chk("fullpp_newest", 64'(last_pop), 64'hBEEFCAFE);

    // Mute on the middle strobe.
    do_reset();
    step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      while (!out_valid && n < 10) begin idle(1'b0); n++; end
      got[i] = {out_l, out_r};
      idle(1'b1);
    end
    chk("mute_s1", 64'(got[0]), 64'h11112222);
    chk("mute_s2", 64'(got[1]), 64'h00000000);
    chk("mute_s3", 64'(got[2]), 64'h55556666);

    // Clear with level 5, overflow set and a same-cycle strobe.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 16'(i), 16'(i), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    for (int n = 0; n < 40 && q.size() > 5; n++) idle(1'b1);
    chk("clr_pre_level", 64'(level), 64'd5);
    chk("clr_pre_ovf", 64'(overflow), 64'd1);
    step(1'b1, 16'h7777, 16'h8888, 1'b0, 1'b0, 1'b1);
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    idle(1'b0);
    chk("clr_discard_valid", 64'(out_valid), 64'd0);
    chk("clr_discard_level", 64'(level), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 99) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
